spi_rom_responder: RTL and testbench

SPI mode-0 flash responder that emulates the read path of a W25Q-series serial flash from an on-chip byte memory. It lets a core that fetches instructions over SPI, such as scrapcpu, run from internal storage with no external flash. The block oversamples the SPI pins in the system clock domain. A parallel load port fills the memory from the management/Wishbone side.

---
 rtl/spi_rom_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_rom_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_responder.sv
// spi_rom_responder
// -----------------------------------------------------------------------------
// SPI mode-0 responder that emulates the read path of a W25Q-series serial
// flash out of an on-chip byte memory, so an SPI instruction fetcher can run
// from internal storage. The SPI pins are oversampled in the clk domain.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous, active-high reset
//   spi_csn      chip select, active low, asynchronous to clk
//   spi_sclk     SPI clock, mode 0 (idles low)
//   spi_mosi     serial data from the initiator
//   spi_miso     serial data to the initiator
//   spi_miso_oe  pad output enable for spi_miso
//   load_en      write strobe for the memory
//   load_addr    memory write address
//   load_data    memory write data
//   busy         high while a transaction is in progress
//   cmd_err      one-cycle pulse on an unsupported opcode
// -----------------------------------------------------------------------------
module spi_rom_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_csn,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SHW   = (ADDR_BITS > 8) ? ADDR_BITS - 1 : 7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]           mem [0:DEPTH-1];

  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                 sclk_d;
  logic                 csn_s;
  logic                 sclk_s;
  logic                 mosi_s;
  logic                 sclk_rise;
  logic                 sclk_fall;

  logic                 armed;
  logic [4:0]           bit_cnt;
  logic [SHW-1:0]       shift_in;
  logic [7:0]           opcode_in;
  logic [ADDR_BITS-1:0] addr_in;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] ptr_inc;
  logic [7:0]           tx;
  logic [1:0]           id_idx;
  logic [1:0]           id_idx_inc;
  logic                 first;
  logic                 tx_now;
  logic                 tx_next;
  logic                 cmd_err_next;

  // JEDEC ID bytes; everything after the third byte reads as zero.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = 8'hEF;
      2'd1:    id_byte = 8'h40;
      2'd2:    id_byte = 8'h18;
      default: id_byte = 8'h00;
    endcase
  endfunction

  assign csn_s      = csn_sync[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;

  // The bit arriving this cycle completes the opcode / address, so decode
  // looks at the shifter concatenated with the live mosi sample.
  assign opcode_in  = {shift_in[6:0], mosi_s};
  assign addr_in    = {shift_in[ADDR_BITS-2:0], mosi_s};
  assign ptr_inc    = ptr + ADDR_BITS'(1);
  assign id_idx_inc = (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;

  assign tx_now     = (state == DATA) || (state == ID);
  assign tx_next    = (state_next == DATA) || (state_next == ID);
  assign busy       = (state != IDLE);

  // Pin synchronizers plus the delayed sclk used for edge detection.
  // Synchronizer flops clear to zero so a csn held low through reset
  // never looks like a fresh high-to-low edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_sync  <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
    end
  end

  // Byte memory written from the management side; never cleared by reset.
  // A read of the same address in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // State register and the registered cmd_err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_next;
      cmd_err <= cmd_err_next;
    end
  end

  // Next-state decode. A synchronized csn high overrides everything and
  // returns to IDLE; a new transaction only starts once csn was seen high.
  always_comb begin
    state_next   = state;
    cmd_err_next = 1'b0;
    if (csn_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            state_next = CMD;
          end
        end
        CMD: begin
          if (sclk_rise && (bit_cnt == 5'd7)) begin
            case (opcode_in)
              8'h03:   state_next = ADDR;
              8'h9F:   state_next = ID;
              default: begin
                state_next   = IGNORE;
                cmd_err_next = 1'b1;
              end
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise && (bit_cnt == 5'd23)) begin
            state_next = DATA;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Datapath: bit counting, input shifting, byte latching and miso drive.
  // The first byte is latched one cycle after entering DATA/ID (the cycle
  // oe rises); later bytes are latched on the eighth sclk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      bit_cnt     <= '0;
      shift_in    <= '0;
      ptr         <= '0;
      tx          <= '0;
      id_idx      <= '0;
      first       <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      if (csn_s) begin
        armed <= 1'b1;
      end else if ((state == IDLE) && (state_next == CMD)) begin
        armed <= 1'b0;
      end

      spi_miso_oe <= tx_now && tx_next;

      if (state_next != state) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
        first    <= 1'b0;
        if (state_next == DATA) begin
          ptr   <= addr_in;
          first <= 1'b1;
        end
        if (state_next == ID) begin
          id_idx <= '0;
          first  <= 1'b1;
        end
      end else begin
        case (state)
          CMD, ADDR: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[SHW-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
          DATA, ID: begin
            if (first) begin
              tx    <= (state == DATA) ? mem[ptr] : id_byte(id_idx);
              first <= 1'b0;
            end else if (sclk_fall) begin
              spi_miso <= tx[7];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (state == DATA) begin
                  ptr <= ptr_inc;
                  tx  <= mem[ptr_inc];
                end else begin
                  id_idx <= id_idx_inc;
                  tx     <= id_byte(id_idx_inc);
                end
              end else begin
                tx      <= {tx[6:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rom_responder.sv
// tb_spi_rom_responder
// -----------------------------------------------------------------------------
// Scoreboarded bench for spi_rom_responder. Stimulus tasks bit-bang the SPI
// pins and push the bytes the initiator should receive into a queue; an
// independent monitor shifts in miso on every sclk rise while oe is high and
// compares each completed byte against the head of the queue.
// -----------------------------------------------------------------------------
module tb_spi_rom_responder;

  localparam int ADDR_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 spi_csn = 1'b1;
  logic                 spi_sclk = 1'b0;
  logic                 spi_mosi = 1'b0;
  logic                 spi_miso;
  logic                 spi_miso_oe;
  logic                 load_en = 1'b0;
  logic [ADDR_BITS-1:0] load_addr = '0;
  logic [7:0]           load_data = '0;
  logic                 busy;
  logic                 cmd_err;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         oe_allowed = 1'b0;
  int         oe_viol = 0;
  int         miso_viol = 0;
  int         err_cnt = 0;

  spi_rom_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_csn    (spi_csn),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  // Sideband watchers sampled on the falling clk edge: oe outside the
  // windows where the stimulus expects it, miso high while oe is low,
  // and the number of cycles cmd_err is high.
  always @(negedge clk) begin
    if (spi_miso_oe && !oe_allowed) oe_viol++;
    if (!spi_miso_oe && spi_miso) miso_viol++;
    if (cmd_err) err_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: acts as the initiator's receiver, sampling miso on sclk rise.
  initial begin : monitor
    int         cnt;
    logic [7:0] sh;
    logic [7:0] want;
    cnt = 0;
    sh  = '0;
    forever begin
      @(posedge spi_sclk or posedge spi_csn);
      if (spi_csn || !spi_miso_oe) begin
        cnt = 0;
      end else begin
        sh = {sh[6:0], spi_miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL extra_byte: got %0h expected none", sh);
          end else begin
            want = exp_q.pop_front();
            checkOutput("miso_byte", {24'h0, sh}, {24'h0, want});
          end
        end
      end
    end
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    waitClk(1);
    load_en   = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    spi_mosi = b;
    waitClk(HALF);
    spi_sclk = 1'b1;
    waitClk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic clockBits(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b0);
  endtask

  task automatic csnLow();
    spi_csn = 1'b0;
    waitClk(4);
  endtask

  task automatic csnHigh(input bit check_busy);
    spi_csn = 1'b1;
    if (check_busy) begin
      waitClk(SYNC_STAGES);
      checkOutput("busy_hold", {31'h0, busy}, 32'h1);
      waitClk(1);
      checkOutput("busy_drop", {31'h0, busy}, 32'h0);
    end else begin
      waitClk(SYNC_STAGES + 1);
    end
    oe_allowed = 1'b0;
    waitClk(6);
  endtask

  // Shifts out the opcode (and address if any); oe becomes legal from the
  // last header bit onwards when a data phase is expected.
  task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr,
                               input bit has_addr, input bit expect_oe);
    logic [31:0] word;
    int          n;
    word = {op, addr};
    n    = has_addr ? 32 : 8;
    for (int i = 0; i < n - 1; i++) sendBit(word[31-i]);
    oe_allowed = expect_oe;
    sendBit(word[31-(n-1)]);
  endtask

  initial begin
    int viol_before;

    // Reset state.
    waitClk(3);
    checkOutput("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    checkOutput("rst_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
    rst = 1'b0;
    waitClk(6);

    // Basic read from address 0.
    $display("[TB] read 03 000000");
    loadByte(8'h00, 8'h3C);
    loadByte(8'h01, 8'hA5);
    loadByte(8'h02, 8'h01);
    loadByte(8'h03, 8'hFF);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    csnLow();
    checkOutput("busy_start", {31'h0, busy}, 32'h1);
    applyStimulus(8'h03, 24'h000000, 1'b1, 1'b1);
    clockBits(32);
    csnHigh(1'b1);
    checkOutput("t1_drain", exp_q.size(), 0);
    checkOutput("t1_oe_leak", oe_viol, 0);

    // Upper address bits ignored, pointer wraps.
    $display("[TB] read 03 0012FE with wrap");
    loadByte(8'hFE, 8'h11);
    loadByte(8'hFF, 8'h22);
    loadByte(8'h00, 8'h33);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    csnLow();
    applyStimulus(8'h03, 24'h0012FE, 1'b1, 1'b1);
    clockBits(24);
    csnHigh(1'b1);
    checkOutput("t2_drain", exp_q.size(), 0);

    // JEDEC ID.
    $display("[TB] read id 9F");
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h18);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    csnLow();
    applyStimulus(8'h9F, 24'h0, 1'b0, 1'b1);
    clockBits(40);
    csnHigh(1'b0);
    checkOutput("t3_drain", exp_q.size(), 0);

    // Unsupported opcode, then a normal read.
    $display("[TB] bad opcode 0B");
    checkOutput("t4_err_before", err_cnt, 0);
    csnLow();
    applyStimulus(8'h0B, 24'h0, 1'b0, 1'b0);
    clockBits(24);
    csnHigh(1'b1);
    checkOutput("t4_err_pulses", err_cnt, 1);
    checkOutput("t4_oe_leak", oe_viol, 0);
    exp_q.push_back(8'h33);
    csnLow();
    applyStimulus(8'h03, 24'h000000, 1'b1, 1'b1);
    clockBits(8);
    csnHigh(1'b0);
    checkOutput("t4_drain", exp_q.size(), 0);

    // Abort after 3 data bits, then read from address 1.
    $display("[TB] abort then read 03 000001");
    csnLow();
    applyStimulus(8'h03, 24'h000000, 1'b1, 1'b1);
    clockBits(3);
    csnHigh(1'b1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    csnLow();
    applyStimulus(8'h03, 24'h000001, 1'b1, 1'b1);
    clockBits(16);
    csnHigh(1'b0);
    checkOutput("t5_drain", exp_q.size(), 0);

    // Reset while streaming with csn held low.
    $display("[TB] reset mid-stream");
    exp_q.push_back(8'h33);
    exp_q.push_back(8'hA5);
    csnLow();
    applyStimulus(8'h03, 24'h000000, 1'b1, 1'b1);
    clockBits(19);
    rst = 1'b1;
    waitClk(1);
    oe_allowed = 1'b0;
    waitClk(1);
    rst = 1'b0;
    checkOutput("t6_busy_rst", {31'h0, busy}, 32'h0);
    checkOutput("t6_oe_rst", {31'h0, spi_miso_oe}, 32'h0);
    viol_before = oe_viol;
    clockBits(16);
    checkOutput("t6_quiet_oe", oe_viol - viol_before, 0);
    checkOutput("t6_busy_quiet", {31'h0, busy}, 32'h0);
    csnHigh(1'b0);
    checkOutput("t6_drain_pre", exp_q.size(), 0);
    exp_q.push_back(8'h33);
    csnLow();
    checkOutput("t6_busy_restart", {31'h0, busy}, 32'h1);
    applyStimulus(8'h03, 24'h000000, 1'b1, 1'b1);
    clockBits(8);
    csnHigh(1'b1);
    checkOutput("t6_drain", exp_q.size(), 0);

    checkOutput("oe_leak_total", oe_viol, 0);
    checkOutput("miso_without_oe", miso_viol, 0);
    checkOutput("cmd_err_total", err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
